// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types and constants for the two-CPU snooping bus controller.
package coherence_bus_ctrl_pkg;

  // cpu_datasel encodings: where the requesting cache takes its fill line from.
  localparam logic [1:0] SOURCE_DMEM       = 2'b00;
  localparam logic [1:0] SOURCE_OTHER_PROC = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StMem,
    StInval
  } bus_state_e;

  // Cache block state, shared with the cache controllers.
  typedef enum logic [1:0] {
    BlkInvalid,
    BlkShared,
    BlkModified
  } blk_state_t;

  // Saturating 16-bit increment for the optional statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves past the finished owner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic [1:0] gnt
);

  logic rr_ptr_q;

  // Preferred CPU wins if requesting, otherwise the other one.
  always_comb begin
    gnt = 2'b00;
    if (rr_ptr_q == 1'b0) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  // Pointer flips to the CPU that did not just finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr_q <= 1'b0;
    else if (done) rr_ptr_q <= ~done_id;
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping bus controller between two cache controllers and unified memory.
// Optional statistics counters are enabled by defining BUS_STATS_EN.
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned UADDR_W = 11,
  parameter int unsigned LINE_W  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   read_miss,
  input  logic [1:0]                   write_miss,
  input  logic [1:0]                   invalidate,
  input  logic [1:0][ADDR_W-1:0]       BICO,
  input  logic [1:0]                   u_re,
  input  logic [1:0]                   u_we,
  input  logic [1:0][UADDR_W-1:0]      u_addr,
  input  logic [1:0][LINE_W-1:0]       d_line,
  input  logic [1:0]                   cpu_search_found,
  input  logic [1:0][LINE_W-1:0]       send_other_proc_data,
  input  logic                         mem_rdy,
  input  logic [LINE_W-1:0]            mem_rd_data,
  output logic [1:0]                   grant,
  output logic [1:0][1:0]              cpu_datasel,
  output logic [1:0]                   cpu_search,
  output logic [1:0][ADDR_W-1:0]       BOCI,
  output logic [1:0]                   invalidate_from_other_cpu,
  output logic [1:0][LINE_W-1:0]       other_proc_data,
  output logic [1:0]                   u_rdy,
  output logic [1:0][LINE_W-1:0]       u_rd_data,
  output logic [UADDR_W-1:0]           mem_addr,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic [LINE_W-1:0]            mem_wr_data
`ifdef BUS_STATS_EN
  ,
  output logic [15:0]                  snoop_hits,
  output logic [15:0]                  mem_txns,
  output logic [15:0]                  invals
`endif
);

  bus_state_e          state_q, state_d;
  logic                owner_q, found_q, wr_q, rdy_seen_q;
  logic [LINE_W-1:0]   line_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          miss_pulse, mem_lvl, arb_req, arb_gnt;
  logic                win_id, done;

  assign miss_pulse = read_miss | write_miss;
  assign mem_lvl    = u_re | u_we;
  assign win_id     = arb_gnt[1];
  assign u_rd_data  = {mem_rd_data, mem_rd_data};

  // Arbitrate only the highest-priority request class: miss > invalidate > memory level.
  always_comb begin
    if (|miss_pulse)      arb_req = miss_pulse;
    else if (|invalidate) arb_req = invalidate;
    else                  arb_req = mem_lvl;
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .done    (done),
    .done_id (owner_q),
    .gnt     (arb_gnt)
  );

  // Next-state and all bus outputs.
  always_comb begin
    state_d                   = state_q;
    done                      = 1'b0;
    grant                     = '0;
    cpu_datasel               = '0;
    cpu_search                = '0;
    BOCI                      = '0;
    invalidate_from_other_cpu = '0;
    other_proc_data           = '0;
    u_rdy                     = '0;
    mem_addr                  = '0;
    mem_re                    = 1'b0;
    mem_we                    = 1'b0;
    mem_wr_data               = '0;
    unique case (state_q)
      StIdle: begin
        if (|miss_pulse) begin
          // Snoop the other cache in the same cycle as the miss.
          cpu_search[~win_id] = 1'b1;
          BOCI[~win_id]       = BICO[win_id];
          state_d             = StGrant;
        end else if (|invalidate) begin
          state_d = StInval;
        end else if (|mem_lvl) begin
          state_d = StMem;
        end
      end
      StGrant: begin
        grant[owner_q]           = 1'b1;
        cpu_datasel[owner_q]     = found_q ? SOURCE_OTHER_PROC : SOURCE_DMEM;
        other_proc_data[owner_q] = line_q;
        if (found_q) begin
          // Write miss served by the other cache: its copy must be dropped.
          if (wr_q) begin
            invalidate_from_other_cpu[~owner_q] = 1'b1;
            BOCI[~owner_q]                      = addr_q;
          end
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StMem;
        end
      end
      StMem: begin
        grant[owner_q] = 1'b1;
        u_rdy[owner_q] = mem_rdy;
        mem_addr       = u_addr[owner_q];
        mem_re         = u_re[owner_q];
        mem_we         = u_we[owner_q];
        mem_wr_data    = d_line[owner_q];
        // Staying while the level is up lets an eviction chain into its refill.
        if (rdy_seen_q && !mem_lvl[owner_q]) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      StInval: begin
        invalidate_from_other_cpu[~owner_q] = 1'b1;
        BOCI[~owner_q]                      = addr_q;
        done                                = 1'b1;
        state_d                             = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register plus the request context latched when leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      found_q    <= 1'b0;
      wr_q       <= 1'b0;
      line_q     <= '0;
      addr_q     <= '0;
      rdy_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && state_d != StIdle) begin
        owner_q <= win_id;
        found_q <= cpu_search_found[~win_id];
        line_q  <= send_other_proc_data[~win_id];
        addr_q  <= BICO[win_id];
        wr_q    <= write_miss[win_id];
      end
      if (state_q != StMem) rdy_seen_q <= 1'b0;
      else if (mem_rdy)     rdy_seen_q <= 1'b1;
    end
  end

`ifdef BUS_STATS_EN
  logic [15:0] snoop_hits_q, mem_txns_q, invals_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snoop_hits_q <= '0;
      mem_txns_q   <= '0;
      invals_q     <= '0;
    end else begin
      if (state_q == StGrant && found_q)        snoop_hits_q <= sat_inc16(snoop_hits_q);
      if (state_q != StMem && state_d == StMem) mem_txns_q   <= sat_inc16(mem_txns_q);
      if (state_q == StIdle && state_d == StInval) invals_q  <= sat_inc16(invals_q);
    end
  end

  assign snoop_hits = snoop_hits_q;
  assign mem_txns   = mem_txns_q;
  assign invals     = invals_q;
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: expectations queued at stimulus, checked at output.
module tb_coherence_bus_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        read_miss, write_miss, invalidate, u_re, u_we, cpu_search_found;
  logic [1:0][12:0]  bico;
  logic [1:0][10:0]  u_addr;
  logic [1:0][63:0]  d_line, sopd;
  logic              mem_rdy;
  logic [63:0]       mem_rd_data;
  logic [1:0]        grant, cpu_search, inval_o, u_rdy;
  logic [1:0][1:0]   cpu_datasel;
  logic [1:0][12:0]  boci;
  logic [1:0][63:0]  opd, u_rd_data;
  logic [10:0]       mem_addr;
  logic              mem_re, mem_we;
  logic [63:0]       mem_wr_data;
`ifdef BUS_STATS_EN
  logic [15:0]       snoop_hits, mem_txns, invals;
`endif

  always #5 clk = ~clk;

  coherence_bus_ctrl dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .read_miss                 (read_miss),
    .write_miss                (write_miss),
    .invalidate                (invalidate),
    .BICO                      (bico),
    .u_re                      (u_re),
    .u_we                      (u_we),
    .u_addr                    (u_addr),
    .d_line                    (d_line),
    .cpu_search_found          (cpu_search_found),
    .send_other_proc_data      (sopd),
    .mem_rdy                   (mem_rdy),
    .mem_rd_data               (mem_rd_data),
    .grant                     (grant),
    .cpu_datasel               (cpu_datasel),
    .cpu_search                (cpu_search),
    .BOCI                      (boci),
    .invalidate_from_other_cpu (inval_o),
    .other_proc_data           (opd),
    .u_rdy                     (u_rdy),
    .u_rd_data                 (u_rd_data),
    .mem_addr                  (mem_addr),
    .mem_re                    (mem_re),
    .mem_we                    (mem_we),
    .mem_wr_data               (mem_wr_data)
`ifdef BUS_STATS_EN
    ,
    .snoop_hits                (snoop_hits),
    .mem_txns                  (mem_txns),
    .invals                    (invals)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  logic mem_re_seen = 1'b0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) if (mem_re) mem_re_seen = 1'b1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow: got %h expected nothing queued", obs);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    read_miss = '0; write_miss = '0; invalidate = '0; u_re = '0; u_we = '0;
    cpu_search_found = '0; bico = '0; u_addr = '0; d_line = '0; sopd = '0;
    mem_rdy = 1'b0; mem_rd_data = '0;
  endtask

  // Bounded wait for the grant to drop, then compare against the queued zero.
  task automatic wait_grant_low(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (grant != 2'b00 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    sb_check(64'(grant));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // Reset values
    @(negedge clk);
    sb_push("rst_grant", 0);        sb_check(64'(grant));
    sb_push("rst_search", 0);       sb_check(64'(cpu_search));
    sb_push("rst_inval", 0);        sb_check(64'(inval_o));
    sb_push("rst_urdy", 0);         sb_check(64'(u_rdy));
    sb_push("rst_mem_strobe", 0);   sb_check(64'({mem_re, mem_we}));
    sb_push("rst_datasel", 0);      sb_check(64'(cpu_datasel));
    sb_push("rst_boci", 0);         sb_check(64'(boci));
    sb_push("rst_mem_addr", 0);     sb_check(64'(mem_addr));
    sb_push("rst_opd", 0);          sb_check(opd[0] | opd[1]);
    drive_edge();
    rst_n = 1'b1;

    // Read miss CPU0 hitting in CPU1
    drive_edge();
    mem_re_seen = 1'b0;
    read_miss[0] = 1'b1; bico[0] = 13'h0104;
    cpu_search_found = 2'b10; sopd[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    sb_push("s1_search", 2'b10);
    sb_push("s1_boci1", 13'h0104);
    @(negedge clk);
    sb_check(64'(cpu_search));
    sb_check(64'(boci[1]));
    drive_edge();
    clear_inputs();
    sb_push("s1_grant", 2'b01);
    sb_push("s1_datasel", 4'b0001);
    sb_push("s1_opd0", 64'hAAAA_BBBB_CCCC_DDDD);
    @(negedge clk);
    sb_check(64'(grant));
    sb_check(64'(cpu_datasel));
    sb_check(opd[0]);
    drive_edge();
    sb_push("s1_idle_grant", 0);
    sb_push("s1_no_mem_re", 0);
    @(negedge clk);
    sb_check(64'(grant));
    sb_check(64'(mem_re_seen));

    // Read miss CPU1 with no snoop hit, served from memory
    drive_edge();
    read_miss[1] = 1'b1; bico[1] = 13'h0ABC;
    sb_push("s2_search", 2'b01);
    sb_push("s2_boci0", 13'h0ABC);
    @(negedge clk);
    sb_check(64'(cpu_search));
    sb_check(64'(boci[0]));
    drive_edge();
    read_miss = '0; u_re[1] = 1'b1; u_addr[1] = 11'h2AB;
    sb_push("s2_grant", 2'b10);
    sb_push("s2_datasel", 0);
    @(negedge clk);
    sb_check(64'(grant));
    sb_check(64'(cpu_datasel));
    drive_edge();
    sb_push("s2_mem_addr", 11'h2AB);
    sb_push("s2_mem_re", 1);
    sb_push("s2_grant_held", 2'b10);
    @(negedge clk);
    sb_check(64'(mem_addr));
    sb_check(64'(mem_re));
    sb_check(64'(grant));
    drive_edge();
    mem_rdy = 1'b1; mem_rd_data = 64'h1234_5678_9ABC_DEF0;
    sb_push("s2_urdy", 2'b10);
    sb_push("s2_urd_data1", 64'h1234_5678_9ABC_DEF0);
    @(negedge clk);
    sb_check(64'(u_rdy));
    sb_check(u_rd_data[1]);
    drive_edge();
    mem_rdy = 1'b0; u_re = '0;
    sb_push("s2_grant_drop", 0);
    wait_grant_low(5);

    // Write miss CPU0 with snoop hit: invalidate CPU1 in the grant cycle
    drive_edge();
    write_miss[0] = 1'b1; bico[0] = 13'h0040; cpu_search_found = 2'b10; sopd[1] = 64'h55;
    drive_edge();
    clear_inputs();
    sb_push("s3_inval", 2'b10);
    sb_push("s3_boci1", 13'h0040);
    sb_push("s3_grant", 2'b01);
    @(negedge clk);
    sb_check(64'(inval_o));
    sb_check(64'(boci[1]));
    sb_check(64'(grant));
    drive_edge();
    sb_push("s3_inval_done", 0);
    @(negedge clk);
    sb_check(64'(inval_o));

    // Colliding invalidates after reset: CPU0 first, CPU1 on the repeat
    drive_edge();
    rst_n = 1'b0;
    drive_edge();
    rst_n = 1'b1;
    drive_edge();
    invalidate = 2'b11; bico[0] = 13'h0111; bico[1] = 13'h0222;
    drive_edge();
    invalidate = '0;
    sb_push("s4a_inval", 2'b10);
    sb_push("s4a_boci1", 13'h0111);
    sb_push("s4a_grant", 0);
    @(negedge clk);
    sb_check(64'(inval_o));
    sb_check(64'(boci[1]));
    sb_check(64'(grant));
    drive_edge();
    invalidate = 2'b11;
    drive_edge();
    invalidate = '0;
    sb_push("s4b_inval", 2'b01);
    sb_push("s4b_boci0", 13'h0222);
    @(negedge clk);
    sb_check(64'(inval_o));
    sb_check(64'(boci[0]));

    // Eviction write chained into a refill read
    drive_edge();
    clear_inputs();
    u_we[0] = 1'b1; u_addr[0] = 11'h155; d_line[0] = 64'hDEAD_BEEF_0000_1111;
    drive_edge();
    sb_push("s5_grant_we", 2'b01);
    sb_push("s5_strobe_we", 2'b01);
    sb_push("s5_wr_data", 64'hDEAD_BEEF_0000_1111);
    @(negedge clk);
    sb_check(64'(grant));
    sb_check(64'({mem_re, mem_we}));
    sb_check(mem_wr_data);
    drive_edge();
    mem_rdy = 1'b1;
    drive_edge();
    mem_rdy = 1'b0; u_we[0] = 1'b0; u_re[0] = 1'b1;
    sb_push("s5_grant_re", 2'b01);
    sb_push("s5_strobe_re", 2'b10);
    @(negedge clk);
    sb_check(64'(grant));
    sb_check(64'({mem_re, mem_we}));
    drive_edge();
    mem_rdy = 1'b1;
    drive_edge();
    mem_rdy = 1'b0;
    sb_push("s5_grant_hold", 2'b01);
    @(negedge clk);
    sb_check(64'(grant));
    drive_edge();
    u_re = '0;
    sb_push("s5_grant_drop", 0);
    wait_grant_low(5);

    // Reset in the middle of a memory transaction
    drive_edge();
    read_miss[0] = 1'b1;
    drive_edge();
    read_miss = '0; u_re[0] = 1'b1; u_addr[0] = 11'h3FF;
    drive_edge();
    sb_push("s6_mem_re", 1);
    @(negedge clk);
    sb_check(64'(mem_re));
    #2;
    rst_n = 1'b0;
    #1;
    sb_push("s6_rst_grant", 0);
    sb_push("s6_rst_strobe", 0);
    sb_push("s6_rst_addr", 0);
    sb_check(64'(grant));
    sb_check(64'({mem_re, mem_we}));
    sb_check(64'(mem_addr));
    clear_inputs();
    drive_edge();
    rst_n = 1'b1;
    drive_edge();
    read_miss[1] = 1'b1; cpu_search_found = 2'b01; sopd[0] = 64'h0F0F_0F0F_F0F0_F0F0;
    drive_edge();
    clear_inputs();
    sb_push("s6_post_grant", 2'b10);
    sb_push("s6_post_datasel", 4'b0100);
    sb_push("s6_post_opd1", 64'h0F0F_0F0F_F0F0_F0F0);
    @(negedge clk);
    sb_check(64'(grant));
    sb_check(64'(cpu_datasel));
    sb_check(opd[1]);

    check_val("sb_drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Snooping bus controller between two cache_controller instances and the single unified data memory.
- Takes each CPU's read_miss/write_miss/invalidate pulses and memory requests; arbitrates round-robin.
- Snoops the other CPU and returns grant, cpu_datasel, BOCI, cpu_search and invalidate_from_other_cpu.
- Multiplexes the granted CPU onto the memory port.

Parameters:
- ADDR_W, 13, byte-level address width (BICO/BOCI).
- UADDR_W, 11, line address width to memory.
- LINE_W, 64, cache line width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- read_miss  in  [1:0]  per-CPU one-cycle read-miss pulse
- write_miss  in  [1:0]  per-CPU one-cycle write-miss pulse
- invalidate  in  [1:0]  per-CPU one-cycle write-hit-on-SHARED pulse
- BICO  in  2x[12:0]  per-CPU request address
- u_re, u_we  in  [1:0]  per-CPU memory read/write request levels
- u_addr  in  2x[10:0]  per-CPU line address
- d_line  in  2x[63:0]  per-CPU write line
- cpu_search_found  in  [1:0]  snoop hit from each CPU's cache
- send_other_proc_data  in  2x[63:0]  snooped line from each CPU
- mem_rdy  in  1  unified memory done
- mem_rd_data  in  [63:0]  unified memory read line
- grant  out  [1:0]  per-CPU bus grant, one-hot or zero
- cpu_datasel  out  2x[1:0]  00 = SOURCE_DMEM, 01 = SOURCE_OTHER_PROC
- cpu_search  out  [1:0]  snoop strobe to each CPU
- BOCI  out  2x[12:0]  snoop/invalidate address to each CPU
- invalidate_from_other_cpu  out  [1:0]  invalidate strobe to each CPU
- other_proc_data  out  2x[63:0]  line forwarded from the other CPU
- u_rdy  out  [1:0]  mem_rdy gated to the granted CPU
- u_rd_data  out  2x[63:0]  mem_rd_data, broadcast
- mem_addr  out  [10:0]  memory address, from the granted CPU
- mem_re, mem_we  out  1  memory strobes, from the granted CPU
- mem_wr_data  out  [63:0]  memory write line, from the granted CPU

Behaviour:
- Reset: state IDLE; rr_ptr = 0. All of grant, cpu_search, invalidate_from_other_cpu, u_rdy, mem_re and mem_we are 0. cpu_datasel = 00; BOCI, other_proc_data and mem_addr are 0.
- Snoop, same cycle as the pulse: a miss pulse on CPU i (i chosen by arbitration) drives cpu_search[o]=1 and BOCI[o]=BICO[i] combinationally, where o = other CPU.
  - Registered at that clock edge: found=cpu_search_found[o], line=send_other_proc_data[o], owner=i.
- FSM states and transitions:
  - IDLE → GRANT (any miss pulse accepted).
  - IDLE → MEM (u_re|u_we level with no miss pulse, i.e. an eviction).
  - IDLE → INVAL (invalidate pulse only).
- GRANT (1 cycle):
  - grant[owner]=1; cpu_datasel[owner] = found ? 01 : 00; other_proc_data[owner]=line.
  - found → IDLE the next cycle.
  - not found → MEM.
  - write_miss with found additionally pulses invalidate_from_other_cpu[o] with BOCI[o]=latched BICO in this cycle.
- MEM:
  - grant[owner] held; memory port muxed from owner; u_rdy[owner]=mem_rdy.
  - Exit to IDLE on the cycle after mem_rdy=1 when the owner's u_re|u_we is 0.
  - Otherwise stay, which covers R_EVICT→R_READMEM chaining.
- INVAL (1 cycle): invalidate_from_other_cpu[o]=1, BOCI[o]=latched BICO[i], grant stays 0 → IDLE.
- Latency:
  - Miss pulse to grant is 1 cycle, required because the requester falls back to IDLE if grant is absent.
  - Invalidate pulse to strobe is 1 cycle.
- Arbitration:
  - Round-robin between the two CPUs; rr_ptr flips to the other CPU after each completed transaction.
  - Pulses arrive only in IDLE; a losing CPU's pulse is dropped, and its controller retries by re-missing.
  - Priority order: miss > invalidate > memory level.
- Simultaneous invalidates from both CPUs in IDLE:
  - The rr winner proceeds to INVAL.
  - The loser is denied: invalidate_from_other_cpu[loser]=1 is driven for the winner's address only.
- A pulse arriving outside IDLE is ignored.
- Reset mid-transaction: immediate return to reset values. No memory strobe survives reset.
- grant is never asserted to both CPUs. mem_re/mem_we are only ever nonzero in MEM.

Optional Feature:
- Macro: BUS_STATS_EN.
- When defined, adds outputs snoop_hits[15:0], mem_txns[15:0] and invals[15:0].
- Each counter increments once per GRANT-with-found, MEM entry or INVAL entry respectively.
- Counters saturate at 16'hFFFF and reset to 0.
- When undefined, none of these ports or flops exist and behaviour is otherwise identical.

Decomposition:
- Package common holds SOURCE_DMEM/SOURCE_OTHER_PROC (moved out of the local params), the bus state enum, and blk_state_t (reused).
- One sub-module, rr_arb2: two requests in, one-hot grant out, rr pointer updated on a done strobe.

Test Plan:
- read_miss[0] with BICO[0]=13'h0104 and cpu_search_found[1]=1, line 64'hAAAA_BBBB_CCCC_DDDD:
  - cpu_search[1]=1 and BOCI[1]=13'h0104 in the same cycle.
  - Next cycle grant[0]=1, cpu_datasel[0]=01, other_proc_data[0]=that line.
  - Then IDLE, with mem_re never asserted.
- read_miss[1] with no snoop hit, mem_rdy 3 cycles later carrying 64'h1234_5678_9ABC_DEF0:
  - cpu_datasel[1]=00 and grant[1] held.
  - mem_addr=u_addr[1]; u_rdy[1] pulses with that data; grant drops after u_re[1] falls.
- write_miss[0] with a snoop hit at 13'h0040:
  - GRANT cycle shows invalidate_from_other_cpu[1]=1 and BOCI[1]=13'h0040.
- invalidate[0] and invalidate[1] asserted together after reset:
  - Only CPU0 is served, with invalidate_from_other_cpu[1]=1.
  - A repeat collision serves CPU1 (rr flip).
- Eviction: u_we[0]=1 then u_re[0]=1 with no pulses:
  - MEM held across both, mem_we then mem_re; exit only when both drop.
- rst_n asserted low mid-MEM: all outputs zero asynchronously; the first request after release is accepted normally.
